// File: rtl/sdio_pkg.sv
// rtl/sdio_pkg.sv - shared types and constants for the SD/SDIO CMD-line engine
package sdio_pkg;

  typedef enum logic [1:0] {
    RESP_NONE      = 2'd0,
    RESP_R48       = 2'd1,
    RESP_R136      = 2'd2,
    RESP_R48_NOCRC = 2'd3
  } resp_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_TURN,
    ST_WAIT,
    ST_RX,
    ST_GAP
  } state_e;

  localparam logic [6:0] CRC7_POLY     = 7'h09;
  localparam int         FRAME_LEN_48  = 48;
  localparam int         FRAME_LEN_136 = 136;
  localparam int         CMD_CRC_BITS  = 40;
  localparam int         R136_HDR_BITS = 8;
  localparam int         TURN_CYCLES   = 2;
  localparam int         NCC_CYCLES    = 8;

endpackage

// File: rtl/sdio_crc7.sv
// rtl/sdio_crc7.sv - serial CRC7 (x^7+x^3+1), MSB-first, clear has priority over enable
module sdio_crc7
  import sdio_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = crc_q[6] ^ bit_i;
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sdio_cmd_engine.sv
// rtl/sdio_cmd_engine.sv - host SD CMD-line engine: 48-bit command TX, R48/R136 RX with checks
// SDIO_CMD_NCC_EN: insert an 8-cycle Ncc gap (busy held) after every terminal event.
module sdio_cmd_engine
  import sdio_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         sd_clk,
  input  logic         rstn,
  input  logic         cmd_sd_rst,
  input  logic         all_sd_rst,
  input  logic         cmd_start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  input  logic         cmd_in,
  output logic         cmd_out,
  output logic         cmd_oe,
  output logic         busy,
  output logic [127:0] resp,
  output logic         cmd_done_event,
  output logic         cmd_index_err_event,
  output logic         cmd_end_err_event,
  output logic         cmd_crc_err_event,
  output logic         cmd_timeout_err_event
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) + 1 > 8) ? $clog2(TIMEOUT_CYCLES) + 1 : 8;

`ifdef SDIO_CMD_NCC_EN
  localparam state_e TERM_STATE = ST_GAP;
`else
  localparam state_e TERM_STATE = ST_IDLE;
`endif

  state_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]     idx_q, idx_d;
  logic [31:0]    arg_q, arg_d;
  resp_type_e     type_q, type_d;
  logic [126:0]   sr_q, sr_d;
  logic [127:0]   resp_q, resp_d;
  // Event vector order: {done, index_err, end_err, crc_err, timeout_err}
  logic [4:0]     ev_q, ev_d;

  logic           crc_clr, crc_en, crc_bit;
  logic [6:0]     crc;
  logic           tx_bit;
  logic [39:0]    tx_frame;
  logic [5:0]     frame_sel;
  logic [2:0]     crc_sel;
  logic [127:0]   sr_shift;
  logic [CNT_W-1:0] rx_last;
  logic           idx_err, end_err, crc_err;

  sdio_crc7 u_crc7 (
    .clk_i  (sd_clk),
    .rst_ni (rstn),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .bit_i  (crc_bit),
    .crc_o  (crc)
  );

  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      arg_q   <= '0;
      type_q  <= RESP_NONE;
      sr_q    <= '0;
      resp_q  <= '0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
      type_q  <= type_d;
      sr_q    <= sr_d;
      resp_q  <= resp_d;
      ev_q    <= ev_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    arg_d    = arg_q;
    type_d   = type_q;
    sr_d     = sr_q;
    resp_d   = resp_q;
    ev_d     = '0;
    crc_clr  = 1'b0;
    crc_en   = 1'b0;
    crc_bit  = tx_bit;
    idx_err  = 1'b0;
    end_err  = 1'b0;
    crc_err  = 1'b0;
    sr_shift = {sr_q, cmd_in};
    rx_last  = (type_q == RESP_R136) ? CNT_W'(FRAME_LEN_136 - 2) : CNT_W'(FRAME_LEN_48 - 2);
    unique case (state_q)
      ST_IDLE: begin
        crc_clr = 1'b1;
        cnt_d   = '0;
        if (cmd_start) begin
          idx_d   = cmd_index;
          arg_d   = cmd_arg;
          type_d  = resp_type_e'(resp_type);
          state_d = ST_TX;
        end
      end
      ST_TX: begin
        crc_en = (cnt_q < CNT_W'(CMD_CRC_BITS));
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(FRAME_LEN_48 - 1)) begin
          cnt_d = '0;
          if (type_q == RESP_NONE) begin
            ev_d[4] = 1'b1;
            state_d = TERM_STATE;
          end else begin
            state_d = ST_TURN;
          end
        end
      end
      ST_TURN: begin
        crc_clr = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(TURN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The start bit is 0, so leaving the CRC cleared here already accounts for it.
        crc_clr = 1'b1;
        if (!cmd_in) begin
          cnt_d   = '0;
          state_d = ST_RX;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          cnt_d   = '0;
          ev_d[0] = 1'b1;
          state_d = TERM_STATE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RX: begin
        sr_d    = sr_shift[126:0];
        cnt_d   = cnt_q + 1'b1;
        crc_bit = cmd_in;
        if (type_q == RESP_R136) begin
          crc_clr = (cnt_q < CNT_W'(R136_HDR_BITS - 1));
          crc_en  = (cnt_q < CNT_W'(FRAME_LEN_136 - R136_HDR_BITS - 1));
        end else begin
          crc_en  = (cnt_q < CNT_W'(CMD_CRC_BITS - 1));
        end
        if (cnt_q == rx_last) begin
          // sr_shift holds the whole frame minus the start bit, end bit at [0].
          end_err = ~cmd_in;
          idx_err = (type_q == RESP_R48) && (sr_shift[45:40] != idx_q);
          crc_err = ((type_q == RESP_R48) || (type_q == RESP_R136)) && (sr_shift[7:1] != crc);
          ev_d    = {~(idx_err | end_err | crc_err), idx_err, end_err, crc_err, 1'b0};
          resp_d  = (type_q == RESP_R136) ? {8'h00, sr_shift[127:8]} : {96'h0, sr_shift[39:8]};
          cnt_d   = '0;
          state_d = TERM_STATE;
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NCC_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (cmd_sd_rst || all_sd_rst) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ev_d    = '0;
    end
    if (all_sd_rst) begin
      resp_d = '0;
    end
  end

  always_comb begin
    tx_frame  = {2'b01, idx_q, arg_q};
    frame_sel = 6'(CMD_CRC_BITS - 1) - cnt_q[5:0];
    crc_sel   = 3'(6'(FRAME_LEN_48 - 2) - cnt_q[5:0]);
    if (cnt_q < CNT_W'(CMD_CRC_BITS)) begin
      tx_bit = tx_frame[frame_sel];
    end else if (cnt_q < CNT_W'(FRAME_LEN_48 - 1)) begin
      tx_bit = crc[crc_sel];
    end else begin
      tx_bit = 1'b1;
    end
    cmd_oe  = (state_q == ST_TX);
    cmd_out = (state_q == ST_TX) ? tx_bit : 1'b1;
    busy    = (state_q != ST_IDLE);
  end

  assign resp                  = resp_q;
  assign cmd_done_event        = ev_q[4];
  assign cmd_index_err_event   = ev_q[3];
  assign cmd_end_err_event     = ev_q[2];
  assign cmd_crc_err_event     = ev_q[1];
  assign cmd_timeout_err_event = ev_q[0];

endmodule

// File: doc/sdio_cmd_engine.md
# sdio_cmd_engine

Host-side SD/SDIO CMD-line engine. Serialises a 48-bit command frame with CRC7, receives an optional 48- or 136-bit response, and checks it for timeout, CRC, end-bit and index errors. It sits between the register block and the CMD pad. Its single-cycle event outputs drive the interrupt/error flag register's cmd_* event inputs directly; the flag register is the consumer end of this interface.

## Interface
- TIMEOUT_CYCLES, 64: response start-bit search window, in sd_clk samples.
- sd_clk  in  1  single clock; CMD driven and sampled on posedge.
- rstn  in  1  asynchronous reset, active-low.
- cmd_sd_rst, all_sd_rst  in  1  synchronous soft resets (abort).
- cmd_start  in  1  one-cycle command request; honoured only when busy=0.
- cmd_index  in  6  command index.
- cmd_arg  in  32  argument.
- resp_type  in  2  0 none; 1 R48 (CRC+index check); 2 R136; 3 R48 no CRC/index check (R3/R4).
- cmd_in  in  1  CMD pad input, already synchronised.
- cmd_out, cmd_oe  out  1  CMD pad drive and enable.
- busy  out  1  engine not idle.
- resp  out  128  captured response.
- cmd_done_event, cmd_index_err_event, cmd_end_err_event, cmd_crc_err_event, cmd_timeout_err_event  out  1  one-cycle pulses.

## Operation
- States: IDLE, TX, TURN, WAIT, RX, GAP.
- IDLE: on cmd_start, latch index/arg/type, go to TX. Writing cmd_start while busy=1 is ignored.
- TX: drive 48 bits MSB first: 0, 1, index[5:0], arg[31:0], CRC7[6:0], 1.
  - CRC7 polynomial x^7+x^3+1, register cleared to 0, computed over the first 40 bits.
- After the end bit, cmd_oe=0.
  - resp_type 0: cmd_done_event, then GAP.
  - Otherwise: TURN for 2 unsampled cycles, then WAIT.
- WAIT: sample cmd_in once per cycle.
  - First 0 is the start bit; go to RX.
  - TIMEOUT_CYCLES samples of 1: cmd_timeout_err_event, then GAP.
- RX: shift in 47 bits (R48) or 135 bits (R136) after the start bit. Checks:
  - End bit must be 1, else cmd_end_err.
  - resp_type 1 only: response index must equal cmd_index, else cmd_index_err.
  - resp_type 1: CRC7 over the 40 bits from start bit through arg.
  - resp_type 2: CRC7 over R[127:8] (120 bits after the 8-bit header), compared with R[7:1].
  - resp_type 3: index and CRC fields ignored.
- Capture:
  - R48: resp[31:0]=arg field, resp[127:32]=0.
  - R136: resp[119:0]=R[127:8], resp[127:120]=0.
- Completion: all failing error events pulse together in the same cycle. cmd_done_event pulses only when no error occurred. Exactly one terminal cycle per command.
- Reset values: cmd_out=1, cmd_oe=0, busy=0, resp=0, all events 0.
- cmd_sd_rst or all_sd_rst in any state:
  - Next cycle: IDLE, cmd_oe=0, busy=0, no events.
  - resp cleared by all_sd_rst only.
- cmd_start coincident with a soft reset: reset wins.

## Timing
- cmd_start at cycle T; busy=1 and start bit driven at T+1; end bit at T+48; cmd_oe=0 at T+49.
- No response: cmd_done_event at T+49.
- Sampling begins T+51. Start bit at cycle S: R48 terminal event at S+48; R136 at S+136. resp is valid in the same cycle.
- Timeout: last sample T+50+TIMEOUT_CYCLES, event at T+51+TIMEOUT_CYCLES.
- busy falls after GAP (see Configuration). Next cmd_start is accepted the cycle busy=0.

## Configuration
- SDIO_CMD_NCC_EN defined: GAP lasts 8 cycles with cmd_oe=0 and busy=1, enforcing Ncc.
- Undefined: GAP is skipped; busy falls in the terminal-event cycle.

## Structure
- Package sdio_pkg holds:
  - resp_type encodings (RESP_NONE, RESP_R48, RESP_R136, RESP_R48_NOCRC);
  - state enum;
  - CRC7 polynomial constant;
  - frame lengths 48/136.
- One sub-module, sdio_crc7: serial CRC7 with clr, en, bit inputs and a 7-bit crc output. It is instantiated once and shared by TX and RX, cleared at each frame start.

## Test plan
- CMD0, arg 0, type 0 -> CMD bits 0x40_00000000_95; cmd_done_event at T+49; no errors.
- CMD8, arg 0x1AA, type 1; card returns 0x08_000001AA_13 with start at T+55 -> TX 0x48_000001AA_87; resp=0x1AA; cmd_done_event at T+103.
- Same response with CRC byte 0x15 and end bit 0 -> cmd_crc_err_event and cmd_end_err_event in the same cycle; no cmd_done_event.
- CMD17, type 1; response index 0x12 -> cmd_index_err_event only. Repeat with type 3 -> cmd_done_event.
- type 1, cmd_in held 1 -> cmd_timeout_err_event at T+115; busy=0 afterwards, or at T+123 with SDIO_CMD_NCC_EN.
- cmd_sd_rst at T+20 mid-TX -> cmd_oe=0 and busy=0 at T+21; no events; new cmd_start accepted at T+21.
